// File: rtl/xnor_corr_pkg.sv
// Shared types and width helpers for the XNOR sync-word correlator.
package xnor_corr_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } corr_state_e;

  // Bits needed to hold a score in 0..width inclusive.
  function automatic int score_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Bitwise XNOR of two words followed by a count of the agreeing bit positions.
module xnor_popcount #(
  parameter int WIDTH   = 8,
  parameter int SCORE_W = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [SCORE_W-1:0] count_o
);

  logic [WIDTH-1:0] eq_s;

  assign eq_s = ~(a_i ^ b_i);

  // Sum the equality bits.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + SCORE_W'(eq_s[i]);
    end
  end

endmodule

// File: rtl/xnor_correlator.sv
// Serial correlator: shifts din into a window, scores it against a pattern,
// flags threshold matches and tracks lock from runs of matches and misses.
module xnor_correlator
  import xnor_corr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LOCK_N  = 3,
  parameter int MISS_N  = 2,
  parameter int HIT_W   = 16,
  parameter int SCORE_W = score_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic               din,
  input  logic [WIDTH-1:0]   pattern,
  input  logic [SCORE_W-1:0] threshold,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic               match,
  output logic               locked,
  output logic [HIT_W-1:0]   hit_count
);

  localparam int RUN_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(MISS_N + 1);
  localparam logic [SCORE_W-1:0] FULL     = SCORE_W'(WIDTH);
  localparam logic [RUN_W-1:0]   RUN_MAX  = RUN_W'(LOCK_N);
  localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(MISS_N);

  logic [WIDTH-1:0]   window_q, window_d, window_sh_s;
  logic [SCORE_W-1:0] fill_q, fill_d;
  logic [SCORE_W-1:0] score_q, score_d, pop_s;
  logic               valid_q, valid_d;
  logic               match_q, match_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  corr_state_e        state_q, state_d;

  assign window_sh_s = {window_q[WIDTH-2:0], din};

  xnor_popcount #(
    .WIDTH   (WIDTH),
    .SCORE_W (SCORE_W)
  ) u_popcount (
    .a_i     (window_sh_s),
    .b_i     (pattern),
    .count_o (pop_s)
  );

  // Next-state logic for the window, scoring, lock FSM and hit counter.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    score_d  = score_q;
    valid_d  = 1'b0;
    match_d  = 1'b0;
    state_d  = state_q;
    run_d    = run_q;
    miss_d   = miss_q;
    hit_d    = hit_q;
    if (en) begin
      window_d = window_sh_s;
      if (fill_q != FULL) begin
        fill_d = fill_q + SCORE_W'(1);
      end else begin
        fill_d = fill_q;
      end
      score_d = pop_s;
      valid_d = (fill_d == FULL);
      match_d = valid_d && (pop_s >= threshold);
      if (valid_d) begin
        // The window completing the fill is judged as a SEARCH window.
        case (state_q)
          FILL, SEARCH: begin
            state_d = SEARCH;
            if (!match_d) begin
              run_d = '0;
            end else if (run_q + RUN_W'(1) >= RUN_MAX) begin
              run_d   = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
          LOCKED: begin
            if (match_d) begin
              miss_d = '0;
            end else if (miss_q + MISS_W'(1) >= MISS_MAX) begin
              miss_d  = '0;
              run_d   = '0;
              state_d = SEARCH;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
          default: begin
            state_d = FILL;
            run_d   = '0;
            miss_d  = '0;
          end
        endcase
      end else begin
        state_d = state_q;
      end
      if (match_d && (hit_q != {HIT_W{1'b1}})) begin
        hit_d = hit_q + HIT_W'(1);
      end else begin
        hit_d = hit_q;
      end
    end else begin
      window_d = window_q;
    end
  end

  // State registers with asynchronous reset and synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      fill_q   <= '0;
      score_q  <= '0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
      state_q  <= FILL;
      run_q    <= '0;
      miss_q   <= '0;
      hit_q    <= '0;
    end else if (clear) begin
      window_q <= '0;
      fill_q   <= '0;
      score_q  <= '0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
      state_q  <= FILL;
      run_q    <= '0;
      miss_q   <= '0;
      hit_q    <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      score_q  <= score_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
      state_q  <= state_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      hit_q    <= hit_d;
    end
  end

  assign score       = score_q;
  assign score_valid = valid_q;
  assign match       = match_q;
  assign locked      = (state_q == LOCKED);
  assign hit_count   = hit_q;

endmodule

// File: tb/tb_xnor_correlator.sv
// Directed bench for xnor_correlator (WIDTH=8, LOCK_N=3, MISS_N=2, HIT_W=2).
module tb_xnor_correlator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] threshold = 4'd0;
  logic [3:0] score;
  logic       score_valid;
  logic       match;
  logic       locked;
  logic [1:0] hit_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xnor_correlator #(
    .WIDTH  (8),
    .LOCK_N (3),
    .MISS_N (2),
    .HIT_W  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .en          (en),
    .din         (din),
    .pattern     (pattern),
    .threshold   (threshold),
    .score       (score),
    .score_valid (score_valid),
    .match       (match),
    .locked      (locked),
    .hit_count   (hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic e, input logic d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic e, input logic d);
    clear = 1'b1;
    send(e, d);
    clear = 1'b0;
  endtask

  logic [7:0] bits;

  initial begin
    #1;
    chk("reset_score", score, 0);
    chk("reset_valid", score_valid, 0);
    chk("reset_locked", locked, 0);
    chk("reset_hits", hit_count, 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exact match against A5.
    pattern = 8'hA5; threshold = 4'd8;
    bits = 8'hA5;
    for (int i = 7; i >= 1; i--) send(1'b1, bits[i]);
    chk("exact_pre_valid", score_valid, 0);
    send(1'b1, bits[0]);
    chk("exact_valid", score_valid, 1);
    chk("exact_score", score, 8);
    chk("exact_match", match, 1);
    chk("exact_hits", hit_count, 1);

    // Asynchronous reset mid-stream, no clock edge needed.
    #2 rst_n = 1'b0;
    #1;
    chk("async_score", score, 0);
    chk("async_valid", score_valid, 0);
    chk("async_match", match, 0);
    chk("async_hits", hit_count, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b1);
      chk("refill_valid", score_valid, 0);
    end

    // Lock after three matches, unlock after two misses.
    do_clear(1'b0, 1'b0);
    pattern = 8'hFF; threshold = 4'd8;
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1);
    chk("lk8_score", score, 8);
    chk("lk8_locked", locked, 0);
    send(1'b1, 1'b1);
    chk("lk9_locked", locked, 0);
    chk("lk9_hits", hit_count, 2);
    send(1'b1, 1'b1);
    chk("lk10_locked", locked, 1);
    chk("lk10_hits", hit_count, 3);
    send(1'b1, 1'b0);
    chk("miss1_score", score, 7);
    chk("miss1_match", match, 0);
    chk("miss1_locked", locked, 1);
    send(1'b1, 1'b0);
    chk("miss2_score", score, 6);
    chk("miss2_locked", locked, 0);
    chk("miss2_hits", hit_count, 3);

    // Lock again, saturate the hit counter, then clear with en high.
    do_clear(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send(1'b1, 1'b1);
    chk("relock", locked, 1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    chk("hit_saturate", hit_count, 3);
    chk("still_locked", locked, 1);
    do_clear(1'b1, 1'b1);
    chk("clr_locked", locked, 0);
    chk("clr_hits", hit_count, 0);
    chk("clr_score", score, 0);
    chk("clr_valid", score_valid, 0);
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b1);
      chk("clr_refill_valid", score_valid, 0);
    end
    send(1'b1, 1'b1);
    chk("clr_8th_valid", score_valid, 1);
    chk("clr_8th_score", score, 8);
    chk("clr_8th_hits", hit_count, 1);

    // Threshold boundaries on window 00010100 vs pattern 00.
    pattern = 8'h00;
    bits = 8'b0001_0100;
    for (int t = 0; t < 2; t++) begin
      do_clear(1'b0, 1'b0);
      threshold = (t == 0) ? 4'd6 : 4'd7;
      for (int i = 7; i >= 0; i--) send(1'b1, bits[i]);
      chk("thr_score", score, 6);
      chk("thr_valid", score_valid, 1);
      chk("thr_match", match, (t == 0) ? 1 : 0);
    end
    do_clear(1'b0, 1'b0);
    threshold = 4'd9;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 1'b0);
      chk("thr9_match", match, 0);
    end
    chk("thr9_score", score, 8);

    // en gaps with threshold 0 (every valid window matches).
    threshold = 4'd0;
    send(1'b1, 1'b1);
    chk("gap1_score", score, 7);
    chk("gap1_valid", score_valid, 1);
    chk("gap1_match", match, 1);
    send(1'b0, 1'b1);
    chk("gap2_score", score, 7);
    chk("gap2_valid", score_valid, 0);
    chk("gap2_match", match, 0);
    send(1'b1, 1'b1);
    chk("gap3_score", score, 6);
    chk("gap3_match", match, 1);
    send(1'b0, 1'b0);
    chk("gap4_score", score, 6);
    chk("gap4_valid", score_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
